// File: rtl/tx_fifo.sv
// tx_fifo: transmit FIFO between the system write port and the output shift
// register. First-word-fall-through: the head word is always on pop_data
// (zero when empty). Sticky overflow/underflow flags record lost traffic.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   push_data/en   word written by the system, one per cycle
//   pop_en         head consumed by the OSR
//   pop_data       head word (combinational from registered state)
//   flush          discard contents; same-cycle push/pop ignored
//   clear_flags    clear overflow/underflow (a same-cycle new event wins)
//   full, empty    level == DEPTH / level == 0
//   level          occupancy 0..DEPTH
//   overflow       sticky: push attempted while full without a pop
//   underflow      sticky: pop attempted while empty
module tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push_en,
  input  logic                     pop_en,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     flush,
  input  logic                     clear_flags,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic push_acc;
  logic pop_acc;
  logic ovf_evt;
  logic udf_evt;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == '0);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign pop_data  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted; flush suppresses every transfer and flag event.
    push_acc = !flush && push_en && (!full || pop_en);
    pop_acc  = !flush && pop_en && !empty;
    ovf_evt  = !flush && push_en && full && !pop_en;
    udf_evt  = !flush && pop_en && empty;

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_acc) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      level_d = level_q + LW'(push_acc) - LW'(pop_acc);
    end

    // Set wins over clear.
    overflow_d  = (clear_flags ? 1'b0 : overflow_q)  | ovf_evt;
    underflow_d = (clear_flags ? 1'b0 : underflow_q) | udf_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset; a write during reset is harmless because level is 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
